// File: rtl/dm_pkg.sv
// Shared constants and payload type for the data-memory responder.
// FSM encodings, word/counter widths, captured request payload and a latency legality helper.
package dm_pkg;

    localparam int unsigned DM_STATE_W    = 2;
    localparam int unsigned DM_WORD_BYTES = 4;
    localparam int unsigned DM_CNT_W      = 4;
    localparam int unsigned DM_DATA_W     = 32;
    localparam int unsigned DM_ADDR_W     = 32;

    localparam logic [DM_STATE_W-1:0] DM_IDLE = 2'd0;
    localparam logic [DM_STATE_W-1:0] DM_BUSY = 2'd1;
    localparam logic [DM_STATE_W-1:0] DM_DONE = 2'd2;

    // Request as captured at acceptance; a read+write request is stored as a write
    typedef struct packed {
        logic                 we;
        logic                 m2r;
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] wdata;
    } dm_req_t;

    // Latency must fit the 4-bit down-counter and be at least one cycle
    function automatic bit dm_latency_ok(input int unsigned lat);
        return (lat >= 1) && (lat <= 15);
    endfunction

endpackage

// File: rtl/dm_sram_array.sv
// Single-port synchronous word RAM with a registered read port.
// Ports: clk, rst_n (clears only the read register), i_we/i_re strobes,
//        i_index word index, i_wdata store data, o_rdata last read word.
module dm_sram_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_index,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    // Storage is never reset; contents survive a reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_index] <= i_wdata;
        end
    end

    // Read register holds the last loaded word between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_index];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_unit.sv
// Data-memory responder for the DM stage: accepts one aligned read/write request,
// performs it LATENCY cycles after acceptance and pulses mem_ready on completion.
// Ports: clk, reset (async, active-low); request inputs Mem_read_in, Mem_write_in,
//        Mem_address, Write_data_in, mem_to_reg_in; outputs Read_data_out,
//        mem_to_reg_out, mem_ready, mem_stall (combinational), misaligned_err, protocol_err.
module data_memory_unit
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_read_in,
    input  logic        Mem_write_in,
    input  logic [31:0] Mem_address,
    input  logic [31:0] Write_data_in,
    input  logic        mem_to_reg_in,
    output logic [31:0] Read_data_out,
    output logic        mem_to_reg_out,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        misaligned_err,
    output logic        protocol_err
);

    localparam int unsigned          IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [DM_CNT_W-1:0]  LAT_M1 = DM_CNT_W'(LATENCY - 1);

    if (!dm_latency_ok(LATENCY)) begin : g_bad_latency
        $error("data_memory_unit: LATENCY must be within 1..15");
    end

    logic [DM_STATE_W-1:0] r_state;
    logic [DM_STATE_W-1:0] w_state_nxt;
    logic [DM_CNT_W-1:0]   r_cnt;
    logic [DM_CNT_W-1:0]   w_cnt_nxt;
    dm_req_t               r_req;
    dm_req_t               w_req_in;
    logic                  r_ready;
    logic                  r_mis;
    logic                  r_prot;

    logic                  w_req;
    logic                  w_aligned;
    logic                  w_accept;
    logic                  w_sram_we;
    logic                  w_sram_re;
    logic [IDX_W-1:0]      w_sram_idx;
    logic [DM_DATA_W-1:0]  w_sram_wd;
    logic                  w_unused_ok;

    // Request decode; both strobes set is treated as a write
    assign w_req     = Mem_read_in | Mem_write_in;
    assign w_aligned = (Mem_address[1:0] == 2'b00);
    assign w_accept  = (r_state == DM_IDLE) & w_req & w_aligned;

    assign w_req_in.we    = Mem_write_in;
    assign w_req_in.m2r   = mem_to_reg_in;
    assign w_req_in.addr  = Mem_address;
    assign w_req_in.wdata = Write_data_in;

    // Next state, counter and RAM strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sram_we   = 1'b0;
        w_sram_re   = 1'b0;
        w_sram_idx  = r_req.addr[IDX_W+1:2];
        w_sram_wd   = r_req.wdata;
        case (r_state)
            DM_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = LAT_M1;
                    if (LATENCY == 1) begin
                        // Single-cycle latency: access straight from the live inputs
                        w_state_nxt = DM_DONE;
                        w_sram_we   = Mem_write_in;
                        w_sram_re   = ~Mem_write_in;
                        w_sram_idx  = Mem_address[IDX_W+1:2];
                        w_sram_wd   = Write_data_in;
                    end else begin
                        w_state_nxt = DM_BUSY;
                    end
                end
            end
            DM_BUSY: begin
                w_cnt_nxt = r_cnt - DM_CNT_W'(1);
                // Access fires on the edge that brings the counter to zero
                if (r_cnt == DM_CNT_W'(1)) begin
                    w_state_nxt = DM_DONE;
                    w_sram_we   = r_req.we;
                    w_sram_re   = ~r_req.we;
                end
            end
            DM_DONE: begin
                w_state_nxt = DM_IDLE;
            end
            default: begin
                w_state_nxt = DM_IDLE;
            end
        endcase
    end

    // State, capture registers and status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= DM_IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_ready <= 1'b0;
            r_mis   <= 1'b0;
            r_prot  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_req <= w_req_in;
            end
            r_ready <= (w_state_nxt == DM_DONE);
            r_mis   <= (r_state == DM_IDLE) & w_req & ~w_aligned;
            r_prot  <= w_accept & Mem_read_in & Mem_write_in;
        end
    end

    dm_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DM_DATA_W),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_sram_we),
        .i_re    (w_sram_re),
        .i_index (w_sram_idx),
        .i_wdata (w_sram_wd),
        .o_rdata (Read_data_out)
    );

    // Hold the pipeline while a request waits in IDLE or is in flight
    assign mem_stall      = w_accept | (r_state == DM_BUSY);
    assign mem_ready      = r_ready;
    assign misaligned_err = r_mis;
    assign protocol_err   = r_prot;
    assign mem_to_reg_out = r_req.m2r;

    // Address bits outside the word index are intentionally ignored
    assign w_unused_ok = ^{Mem_address[31:IDX_W+2], r_req.addr[31:IDX_W+2], r_req.addr[1:0]};

endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;

    localparam int NI    = 3;
    localparam int DEPTH = 256;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        rd_in  = 1'b0;
    logic        wr_in  = 1'b0;
    logic        m2r_in = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] wd_in   = '0;

    logic [31:0] rdo  [NI];
    logic        m2ro [NI];
    logic        rdy  [NI];
    logic        stl  [NI];
    logic        mis  [NI];
    logic        prot [NI];

    always #5 clk = ~clk;

    // Three instances share the stimulus: LATENCY 1, 2 and 15
    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_memory_unit #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     ((g == 0) ? 1 : (g == 1) ? 2 : 15)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .Mem_read_in    (rd_in),
            .Mem_write_in   (wr_in),
            .Mem_address    (addr_in),
            .Write_data_in  (wd_in),
            .mem_to_reg_in  (m2r_in),
            .Read_data_out  (rdo[g]),
            .mem_to_reg_out (m2ro[g]),
            .mem_ready      (rdy[g]),
            .mem_stall      (stl[g]),
            .misaligned_err (mis[g]),
            .protocol_err   (prot[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 15;
    endfunction

    // Reference model: each instance is a server that is free again LATENCY+1
    // edges after an acceptance and delivers its result LATENCY-1 edges after it.
    int          cyc;
    int          free_e [NI];
    int          done_e [NI];
    logic        p_wr   [NI];
    logic [7:0]  p_idx  [NI];
    logic [31:0] p_wd   [NI];
    logic [31:0] mm     [NI][DEPTH];
    bit          kn     [NI][DEPTH];
    logic [31:0] e_rd   [NI];
    bit          e_rdk  [NI];
    logic        e_m2r  [NI];
    logic        e_rdy  [NI];
    logic        e_mis  [NI];
    logic        e_prot [NI];

    logic [31:0] smp_rd  [NI];
    logic        smp_rdy [NI];
    logic        smp_stl [NI];
    logic        smp_mis [NI];
    logic        smp_prot[NI];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst%0d got=%h exp=%h t=%0t", nm, i, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            free_e[i] = 0;
            done_e[i] = -1;
            e_rd[i]   = '0;
            e_rdk[i]  = 1'b1;
            e_m2r[i]  = 1'b0;
            e_rdy[i]  = 1'b0;
            e_mis[i]  = 1'b0;
            e_prot[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        int lat;
        if (!reset) begin
            model_reset();
        end else begin
            cyc++;
            for (int i = 0; i < NI; i++) begin
                lat       = lat_of(i);
                e_rdy[i]  = 1'b0;
                e_mis[i]  = 1'b0;
                e_prot[i] = 1'b0;
                if (cyc >= free_e[i] && (rd_in || wr_in)) begin
                    if (addr_in[1:0] != 2'b00) begin
                        e_mis[i] = 1'b1;
                    end else begin
                        p_wr[i]   = wr_in;
                        p_idx[i]  = addr_in[9:2];
                        p_wd[i]   = wd_in;
                        e_m2r[i]  = m2r_in;
                        e_prot[i] = rd_in && wr_in;
                        done_e[i] = cyc + lat - 1;
                        free_e[i] = cyc + lat + 1;
                    end
                end
                if (cyc == done_e[i]) begin
                    e_rdy[i] = 1'b1;
                    if (p_wr[i]) begin
                        mm[i][p_idx[i]] = p_wd[i];
                        kn[i][p_idx[i]] = 1'b1;
                    end else begin
                        e_rd[i]  = mm[i][p_idx[i]];
                        e_rdk[i] = kn[i][p_idx[i]];
                    end
                end
            end
        end
    endtask

    // Stall seen before the next edge: busy until delivery, else a waiting aligned request
    function automatic logic exp_stall(input int i);
        if (cyc + 1 >= free_e[i]) return (rd_in || wr_in) && (addr_in[1:0] == 2'b00);
        return (cyc + 1 <= done_e[i]);
    endfunction

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            if (e_rdk[i]) chk("Read_data_out", i, rdo[i], e_rd[i]);
            chk("mem_to_reg_out", i, 32'(m2ro[i]), 32'(e_m2r[i]));
            chk("mem_ready",      i, 32'(rdy[i]),  32'(e_rdy[i]));
            chk("misaligned_err", i, 32'(mis[i]),  32'(e_mis[i]));
            chk("protocol_err",   i, 32'(prot[i]), 32'(e_prot[i]));
            chk("mem_stall",      i, 32'(stl[i]),  32'(exp_stall(i)));
            smp_rd[i]   = rdo[i];
            smp_rdy[i]  = rdy[i];
            smp_stl[i]  = stl[i];
            smp_mis[i]  = mis[i];
            smp_prot[i] = prot[i];
        end
    endtask

    // Compare mid-cycle, advance one edge, return just after it
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Issue a request and hold it until instance k completes (plus the DONE edge)
    task automatic access(input int k, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic mr,
                          output int stalls, output logic [31:0] rdval, output bit saw_prot);
        bit got;
        rd_in = r; wr_in = w; addr_in = a; wd_in = d; m2r_in = mr;
        stalls = 0; got = 1'b0; saw_prot = 1'b0; rdval = '0;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            if (smp_stl[k])  stalls++;
            if (smp_prot[k]) saw_prot = 1'b1;
            if (smp_rdy[k]) begin
                got   = 1'b1;
                rdval = smp_rd[k];
            end
        end
        chk("ready_seen", k, 32'(got), 32'd1);
        rd_in = 1'b0; wr_in = 1'b0;
    endtask

    initial begin
        int          st;
        logic [31:0] rv;
        bit          pr;
        int          last_r [NI];
        int          scnt   [NI];

        cyc = 0;
        model_reset();
        repeat (3) tick();
        // Reset state
        chk("rst_Read_data_out",  1, rdo[1], 32'h0);
        chk("rst_mem_to_reg_out", 1, 32'(m2ro[1]), 32'd0);
        chk("rst_mem_ready",      1, 32'(rdy[1]),  32'd0);
        chk("rst_mem_stall",      1, 32'(stl[1]),  32'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Write then read back with two-cycle latency
        access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, st, rv, pr);
        chk("t1_wr_stall", 1, 32'(st), 32'd2);
        access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, st, rv, pr);
        chk("t1_rd_stall", 1, 32'(st), 32'd2);
        chk("t1_rd_data",  1, rv, 32'hDEADBEEF);

        // Misaligned read is rejected without stall or completion
        rd_in = 1'b1; addr_in = 32'h12;
        tick();
        chk("t2_stall", 1, 32'(smp_stl[1]), 32'd0);
        rd_in = 1'b0;
        tick();
        chk("t2_mis",   1, 32'(smp_mis[1]), 32'd1);
        chk("t2_ready", 1, 32'(smp_rdy[1]), 32'd0);
        chk("t2_rdata", 1, smp_rd[1], 32'hDEADBEEF);
        tick();
        chk("t2_mis_pulse", 1, 32'(smp_mis[1]), 32'd0);

        // Read+write together behaves as a write and flags protocol_err
        access(1, 1'b1, 1'b1, 32'h20, 32'h5, 1'b0, st, rv, pr);
        chk("t3_prot", 1, 32'(pr), 32'd1);
        access(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, st, rv, pr);
        chk("t3_rd_data", 1, rv, 32'h5);

        // Address wrap at 256 words
        access(1, 1'b0, 1'b1, 32'h0,   32'h1, 1'b0, st, rv, pr);
        access(1, 1'b0, 1'b1, 32'h400, 32'h2, 1'b0, st, rv, pr);
        access(1, 1'b1, 1'b0, 32'h0,   32'h0, 1'b0, st, rv, pr);
        chk("t4_wrap", 1, rv, 32'h2);

        // Reset during an in-flight write discards it
        access(1, 1'b0, 1'b1, 32'h8, 32'h11, 1'b1, st, rv, pr);
        wr_in = 1'b1; addr_in = 32'h8; wd_in = 32'hAA; m2r_in = 1'b1;
        tick();
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        wr_in = 1'b0;
        #1;
        chk("t5_rdata", 1, rdo[1], 32'h0);
        chk("t5_m2r",   1, 32'(m2ro[1]), 32'd0);
        chk("t5_ready", 1, 32'(rdy[1]),  32'd0);
        chk("t5_stall", 1, 32'(stl[1]),  32'd0);
        @(posedge clk);
        model_step();
        #1;
        tick();
        #2;
        reset = 1'b1;
        tick();
        access(1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, st, rv, pr);
        chk("t5_prior", 1, rv, 32'h11);

        // Back-to-back reads: pulse spacing LATENCY+1, stall LATENCY cycles between
        for (int i = 0; i < NI; i++) begin last_r[i] = -1; scnt[i] = 0; end
        rd_in = 1'b1; addr_in = 32'h10;
        for (int n = 0; n < 60; n++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                if (smp_rdy[i]) begin
                    if (last_r[i] >= 0) begin
                        chk("t6_spacing", i, 32'(n - last_r[i]), 32'(lat_of(i) + 1));
                        chk("t6_stalls",  i, 32'(scnt[i]),       32'(lat_of(i)));
                    end
                    last_r[i] = n;
                    scnt[i]   = 0;
                end else if (smp_stl[i]) begin
                    scnt[i]++;
                end
            end
        end
        rd_in = 1'b0;
        repeat (20) tick();

        // Fill every word of every instance, paced by the slowest one
        for (int w = 0; w < DEPTH; w++) begin
            access(2, 1'b0, 1'b1, 32'(w * 4), $urandom, 1'($urandom_range(0, 1)), st, rv, pr);
        end

        // Random traffic, inputs occasionally held across several cycles
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                int r;
                r       = $urandom_range(0, 9);
                rd_in   = (r <= 3) || (r == 7);
                wr_in   = (r >= 4) && (r <= 7);
                addr_in = $urandom;
                if ($urandom_range(0, 7) != 0) addr_in[1:0] = 2'b00;
                wd_in   = $urandom;
                m2r_in  = 1'($urandom_range(0, 1));
            end
            tick();
        end
        rd_in = 1'b0; wr_in = 1'b0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
